// File: rtl/pixel_tap_gen_pkg.sv
// Shared camera-path definitions: coordinate width, FSM states, default pixel depth.
package pixel_tap_gen_pkg;

    localparam int COORD_W     = 11;
    localparam int P_DEPTH_DEF = 10;

    typedef enum logic {
        WAIT_VS = 1'b0,
        ACTIVE  = 1'b1
    } state_e;

endpackage

// File: rtl/pixel_tap_gen_if.sv
// Pixel stream in / tap bundle out. The tap side matches the crop stage input bundle.
interface pixel_tap_gen_if
    import pixel_tap_gen_pkg::*;
#(
    parameter int P_DEPTH = P_DEPTH_DEF
);
    logic               in_vs;
    logic               in_hs;
    logic               in_valid;
    logic [P_DEPTH-1:0] in_data;
    logic [COORD_W-1:0] out_x;
    logic [COORD_W-1:0] out_y;
    logic               out_valid;
    logic [P_DEPTH-1:0] out_data_00;
    logic [P_DEPTH-1:0] out_data_01;
    logic [P_DEPTH-1:0] out_data_10;
    logic               out_ovf;

    // Sensor side drives the stream and observes the taps.
    modport master (
        output in_vs, in_hs, in_valid, in_data,
        input  out_x, out_y, out_valid, out_data_00, out_data_01, out_data_10, out_ovf
    );

    // Tap generator side.
    modport slave (
        input  in_vs, in_hs, in_valid, in_data,
        output out_x, out_y, out_valid, out_data_00, out_data_01, out_data_10, out_ovf
    );
endinterface

// File: rtl/pixel_tap_gen_line_ram.sv
// Line buffer: simple dual-port RAM, synchronous write, registered read. No reset so it maps to block RAM.
module pixel_tap_gen_line_ram #(
    parameter int DEPTH = 2048,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port and registered read port.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/pixel_tap_gen.sv
// Pixel coordinate and 3-tap neighbourhood generator (current, left, above).
// Optional build macro: PIXEL_TAP_EDGE_REPLICATE_EN - boundary taps copy the current
// pixel instead of being forced to zero.
module pixel_tap_gen
    import pixel_tap_gen_pkg::*;
#(
    parameter int P_DEPTH    = P_DEPTH_DEF,
    parameter int P_LINE_MAX = 2048
) (
    input  logic           in_pclk,
    input  logic           in_rst,
    pixel_tap_gen_if.slave bus
);
    localparam int AW  = $clog2(P_LINE_MAX);
    // One extra bit so the column counter can sit at P_LINE_MAX (2048 included).
    localparam int XCW = COORD_W + 1;

    state_e               state_q, state_d;
    logic                 vs_q, hs_q;
    logic [XCW-1:0]       x_q, x_d;
    logic [COORD_W-1:0]   y_q, y_d;
    logic                 ovf_q, ovf_d;
    logic                 s1_vld_q, s1_vld_d;
    logic [COORD_W-1:0]   s1_x_q, s1_x_d, s1_y_q, s1_y_d;
    logic [P_DEPTH-1:0]   s1_data_q, s1_data_d;
    logic [P_DEPTH-1:0]   left_q, left_d;
    logic                 out_vld_q, out_vld_d;
    logic [COORD_W-1:0]   out_x_q, out_x_d, out_y_q, out_y_d;
    logic [P_DEPTH-1:0]   out00_q, out00_d, out01_q, out01_d, out10_q, out10_d;

    logic                 vs_rise, hs_fall, run, beat, drop;
    logic [XCW-1:0]       x_cur;
    logic [COORD_W-1:0]   y_cur;
    logic [P_DEPTH-1:0]   ram_rdata, edge_val;

    // Strobe edges against the registered copies.
    always_comb begin
        vs_rise = bus.in_vs & ~vs_q;
        hs_fall = ~bus.in_hs & hs_q;
    end

    // FSM next state: leave WAIT_VS on the first frame strobe, then stay ACTIVE.
    always_comb begin
        state_d = state_q;
        if (state_q == WAIT_VS && vs_rise) state_d = ACTIVE;
    end

    // FSM output: accept pixels when active or on the frame-start cycle itself.
    always_comb begin
        run = (state_q == ACTIVE) || vs_rise;
    end

    // Input stage: coordinates, overflow drop, counters and RAM read address.
    always_comb begin
        x_cur     = vs_rise ? '0 : x_q;
        y_cur     = vs_rise ? '0 : y_q;
        beat      = run && bus.in_valid && (x_cur != XCW'(P_LINE_MAX));
        drop      = run && bus.in_valid && (x_cur == XCW'(P_LINE_MAX));
        x_d       = x_q;
        y_d       = y_q;
        ovf_d     = ovf_q;
        if (run) begin
            x_d   = x_cur + XCW'(beat);
            y_d   = y_cur;
            ovf_d = (ovf_q && !vs_rise) || drop;
            if (hs_fall) begin
                // The beat on the falling edge still belongs to the ending line.
                x_d = '0;
                if (y_cur != '1) y_d = y_cur + 1'b1;
            end
        end
        s1_vld_d  = beat;
        s1_x_d    = beat ? x_cur[COORD_W-1:0] : s1_x_q;
        s1_y_d    = beat ? y_cur : s1_y_q;
        s1_data_d = beat ? bus.in_data : s1_data_q;
    end

`ifdef PIXEL_TAP_EDGE_REPLICATE_EN
    assign edge_val = s1_data_q;
`else
    assign edge_val = '0;
`endif

    // Output stage: assemble taps, mask frame/line boundaries, hold between beats.
    always_comb begin
        out_vld_d = s1_vld_q;
        out_x_d   = out_x_q;
        out_y_d   = out_y_q;
        out00_d   = out00_q;
        out01_d   = out01_q;
        out10_d   = out10_q;
        left_d    = left_q;
        if (s1_vld_q) begin
            out_x_d = s1_x_q;
            out_y_d = s1_y_q;
            out00_d = s1_data_q;
            out01_d = (s1_x_q == '0) ? edge_val : left_q;
            // Row 0 reads stale buffer contents; the mask hides them.
            out10_d = (s1_y_q == '0) ? edge_val : ram_rdata;
            left_d  = s1_data_q;
        end
    end

    // State and pipeline registers; reset flushes everything but the RAM.
    always_ff @(posedge in_pclk) begin
        if (in_rst) begin
            state_q   <= WAIT_VS;
            vs_q      <= 1'b0;
            hs_q      <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            ovf_q     <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_x_q    <= '0;
            s1_y_q    <= '0;
            s1_data_q <= '0;
            left_q    <= '0;
            out_vld_q <= 1'b0;
            out_x_q   <= '0;
            out_y_q   <= '0;
            out00_q   <= '0;
            out01_q   <= '0;
            out10_q   <= '0;
        end else begin
            state_q   <= state_d;
            vs_q      <= bus.in_vs;
            hs_q      <= bus.in_hs;
            x_q       <= x_d;
            y_q       <= y_d;
            ovf_q     <= ovf_d;
            s1_vld_q  <= s1_vld_d;
            s1_x_q    <= s1_x_d;
            s1_y_q    <= s1_y_d;
            s1_data_q <= s1_data_d;
            left_q    <= left_d;
            out_vld_q <= out_vld_d;
            out_x_q   <= out_x_d;
            out_y_q   <= out_y_d;
            out00_q   <= out00_d;
            out01_q   <= out01_d;
            out10_q   <= out10_d;
        end
    end

    // Read on the input beat, write the same column one cycle later: no same-line collision.
    pixel_tap_gen_line_ram #(
        .DEPTH (P_LINE_MAX),
        .WIDTH (P_DEPTH)
    ) u_line_ram (
        .clk   (in_pclk),
        .we    (s1_vld_q),
        .waddr (s1_x_q[AW-1:0]),
        .wdata (s1_data_q),
        .re    (beat),
        .raddr (x_cur[AW-1:0]),
        .rdata (ram_rdata)
    );

    assign bus.out_valid   = out_vld_q;
    assign bus.out_x       = out_x_q;
    assign bus.out_y       = out_y_q;
    assign bus.out_data_00 = out00_q;
    assign bus.out_data_01 = out01_q;
    assign bus.out_data_10 = out10_q;
    assign bus.out_ovf     = ovf_q;
endmodule

// File: tb/tb_pixel_tap_gen.sv
// Scoreboard bench for pixel_tap_gen: frames are generated, the expected neighbourhood of
// every accepted pixel is queued, and a monitor checks each out_valid beat against it.
module tb_pixel_tap_gen;
    import pixel_tap_gen_pkg::*;

    localparam int LM = 8;

    typedef struct {
        int         issue;
        int         x;
        int         y;
        logic [9:0] d00;
        logic [9:0] d01;
        logic [9:0] d10;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t mon_e;

    pixel_tap_gen_if #(.P_DEPTH(10)) bus();

    pixel_tap_gen #(.P_DEPTH(10), .P_LINE_MAX(LM)) dut (
        .in_pclk (clk),
        .in_rst  (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [9:0] edge_val(input logic [9:0] p);
`ifdef PIXEL_TAP_EDGE_REPLICATE_EN
        return p;
`else
        return 10'd0;
`endif
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic vs, input logic hs, input logic v, input logic [9:0] d, input logic r);
        bus.in_vs    = vs;
        bus.in_hs    = hs;
        bus.in_valid = v;
        bus.in_data  = d;
        rst          = r;
        @(posedge clk);
        #1;
    endtask

    // One frame of w x h pixels. gap: 0 none, 1 random, 2 between every pixel.
    // Reset is asserted on pixel (rx,ry) if reached, aborting the frame.
    task automatic run_frame(input int w, input int h, input bit ramp, input bit vs_pix,
                             input int gap, input int rx, input int ry);
        logic [9:0] cur [16];
        logic [9:0] prv [16];
        bit         ovf_e;
        bit         fall_pix;
        bit         vs_now;
        logic [9:0] p;
        exp_t       e;
        ovf_e = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cur[i] = '0;
            prv[i] = '0;
        end
        if (!vs_pix) begin
            drive(1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
            @(negedge clk);
            chk("ovf_clear_on_vs", int'(bus.out_ovf), 0);
        end
        for (int y = 0; y < h; y++) begin
            fall_pix = (w > 1) && ($urandom_range(0, 1) == 1);
            for (int x = 0; x < w; x++) begin
                if (gap == 2 && x > 0) drive(1'b0, 1'b1, 1'b0, 10'd0, 1'b0);
                else if (gap == 1 && x > 0 && $urandom_range(0, 3) == 0) drive(1'b0, 1'b1, 1'b0, 10'd0, 1'b0);
                p = ramp ? 10'(16 * y + x) : 10'($urandom);
                vs_now = vs_pix && (y == 0) && (x == 0);
                if (x == rx && y == ry) begin
                    // Beats issued in this or the previous cycle are flushed by reset.
                    while (sb.size() > 0 && sb[$].issue >= cyc - 1) void'(sb.pop_back());
                    drive(vs_now, 1'b1, 1'b1, p, 1'b1);
                    @(negedge clk);
                    chk("rst_valid", int'(bus.out_valid), 0);
                    chk("rst_x", int'(bus.out_x), 0);
                    chk("rst_y", int'(bus.out_y), 0);
                    chk("rst_ovf", int'(bus.out_ovf), 0);
                    return;
                end
                if (x < LM) begin
                    e.issue = cyc;
                    e.x     = x;
                    e.y     = y;
                    e.d00   = p;
                    e.d01   = (x == 0) ? edge_val(p) : cur[x-1];
                    e.d10   = (y == 0) ? edge_val(p) : prv[x];
                    sb.push_back(e);
                    cur[x]  = p;
                end else begin
                    ovf_e = 1'b1;
                end
                drive(vs_now, !(fall_pix && x == w - 1), 1'b1, p, 1'b0);
            end
            if (!fall_pix) drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
            drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
            prv = cur;
        end
        repeat (3) drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        chk("ovf_flag", int'(bus.out_ovf), int'(ovf_e));
    endtask

    // Monitor: every out_valid beat must match the oldest expected pixel.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_valid: got out_valid=1 at (%0d,%0d), required no output", bus.out_x, bus.out_y);
            end else begin
                mon_e = sb.pop_front();
                chk("latency", cyc - mon_e.issue, 2);
                chk("out_x", int'(bus.out_x), mon_e.x);
                chk("out_y", int'(bus.out_y), mon_e.y);
                chk("data_00", int'(bus.out_data_00), int'(mon_e.d00));
                chk("data_01", int'(bus.out_data_01), int'(mon_e.d01));
                chk("data_10", int'(bus.out_data_10), int'(mon_e.d10));
            end
        end
    end

    initial begin
        bus.in_vs = 1'b0; bus.in_hs = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b1);
        @(negedge clk);
        chk("reset_valid", int'(bus.out_valid), 0);
        chk("reset_x", int'(bus.out_x), 0);
        chk("reset_y", int'(bus.out_y), 0);
        chk("reset_d00", int'(bus.out_data_00), 0);
        chk("reset_d01", int'(bus.out_data_01), 0);
        chk("reset_d10", int'(bus.out_data_10), 0);
        chk("reset_ovf", int'(bus.out_ovf), 0);
        // Pixels before any frame strobe are ignored.
        repeat (3) drive(1'b0, 1'b1, 1'b1, 10'($urandom), 1'b0);
        drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        // 4x3 ramp frame, then a line with 1-0-1 valid gaps.
        run_frame(4, 3, 1'b1, 1'b0, 0, -1, -1);
        run_frame(3, 2, 1'b1, 1'b0, 2, -1, -1);
        // Over-long lines set the sticky overflow; the next frame start clears it.
        run_frame(10, 2, 1'b1, 1'b0, 0, -1, -1);
        run_frame(4, 2, 1'b1, 1'b1, 1, -1, -1);
        // Reset mid-line at (5,2), stray pixels in WAIT_VS, then a fresh frame.
        run_frame(8, 3, 1'b1, 1'b0, 0, 5, 2);
        repeat (2) drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        repeat (3) drive(1'b0, 1'b1, 1'b1, 10'($urandom), 1'b0);
        drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        run_frame(6, 2, 1'b1, 1'b0, 0, -1, -1);
        // Back-to-back frames with different data: row 0 must not show the old line.
        run_frame(5, 2, 1'b0, 1'b0, 0, -1, -1);
        run_frame(5, 2, 1'b0, 1'b0, 0, -1, -1);
        // Randomized frames.
        for (int f = 0; f < 12; f++)
            run_frame($urandom_range(1, 10), $urandom_range(1, 4), 1'b0,
                      1'($urandom_range(0, 1)), 1, -1, -1);
        repeat (4) drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        chk("leftover_expected", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
